// File: rtl/maxpool_relu.sv
// Streaming P x P max-pool with optional ReLU over an M x M raster stream.
// Horizontal maxima fold into a one-row partial-max buffer; one pooled output per window.
module maxpool_relu #(
  parameter int dataWidth = 16,
  parameter int M         = 26,
  parameter int P         = 2,
  parameter int RELU      = 1
) (
  input  logic                 clk,
  input  logic                 global_rst,
  input  logic                 ce,
  input  logic [dataWidth-1:0] data_in,
  input  logic                 valid_in,
  output logic [dataWidth-1:0] data_out,
  output logic                 valid_out,
  output logic                 end_pool
);
  localparam int CW = $clog2(M) + 1;
  localparam int PW = $clog2(P) + 1;
  localparam int NW = M / P;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(M - 1);
  localparam logic [CW-1:0] MU_C     = CW'((M / P) * P);
  localparam logic [CW-1:0] IDX_LAST = CW'(NW - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(P - 1);

  function automatic logic signed [dataWidth-1:0] smax(
    input logic signed [dataWidth-1:0] a,
    input logic signed [dataWidth-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  // col/row are the raster position; cph/rph are position within a window and
  // cidx/ridx the window index, kept as counters to avoid dividers.
  logic [CW-1:0] col, row, cidx, ridx;
  logic [PW-1:0] cph, rph;
  logic signed [dataWidth-1:0] din, hmax, hcur, bcur, vmax;
  logic signed [dataWidth-1:0] pbuf [NW];
  logic accept, usable, grp_end, win_done, frame_end;

  always_comb begin
    din       = $signed(data_in);
    accept    = ce & valid_in;
    usable    = (col < MU_C) && (row < MU_C);
    hcur      = (cph == '0) ? din : smax(hmax, din);
    bcur      = pbuf[cidx[IW-1:0]];
    vmax      = (rph == '0) ? hcur : smax(bcur, hcur);
    grp_end   = accept & usable & (cph == PH_LAST);
    win_done  = grp_end & (rph == PH_LAST);
    frame_end = win_done & (cidx == IDX_LAST) & (ridx == IDX_LAST);
  end

  always_ff @(posedge clk or negedge global_rst) begin
    if (!global_rst) begin
      col  <= '0;
      row  <= '0;
      cph  <= '0;
      rph  <= '0;
      cidx <= '0;
      ridx <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col  <= '0;
        cph  <= '0;
        cidx <= '0;
        if (row == COL_LAST) begin
          row  <= '0;
          rph  <= '0;
          ridx <= '0;
        end else begin
          row  <= row + CW'(1);
          rph  <= (rph == PH_LAST) ? '0 : rph + PW'(1);
          ridx <= ridx + CW'(rph == PH_LAST);
        end
      end else begin
        col  <= col + CW'(1);
        cph  <= (cph == PH_LAST) ? '0 : cph + PW'(1);
        cidx <= cidx + CW'(cph == PH_LAST);
      end
    end
  end

  always_ff @(posedge clk or negedge global_rst) begin
    if (!global_rst) hmax <= '0;
    else if (accept && usable) hmax <= hcur;
  end

  // Every entry is written on row phase 0 before any read, so no reset needed.
  always_ff @(posedge clk) begin
    if (grp_end) pbuf[cidx[IW-1:0]] <= vmax;
  end

  always_ff @(posedge clk or negedge global_rst) begin
    if (!global_rst) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      end_pool  <= 1'b0;
    end else begin
      valid_out <= win_done;
      end_pool  <= frame_end;
      if (win_done) data_out <= (RELU != 0 && vmax[dataWidth-1]) ? '0 : vmax;
    end
  end
endmodule

// File: tb/tb_maxpool_relu.sv
// Self-checking bench for maxpool_relu: directed scenarios plus randomized frames
// checked against a window-max reference model.
module tb_maxpool_relu;
  typedef struct packed {logic v; logic e; logic [15:0] d;} out_t;

  logic clk = 1'b0, global_rst = 1'b1, ce = 1'b0, valid_in = 1'b0;
  logic [15:0] data_in = '0;
  logic [15:0] da, db, dc, dd;
  logic va, vb, vc, vd, ea, eb, ec, ed;
  out_t got_a[$], got_b[$], got_c[$], got_d[$], exp_q[$];
  int nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  maxpool_relu #(.dataWidth(16), .M(4), .P(2), .RELU(0)) u_a (.clk(clk), .global_rst(global_rst),
    .ce(ce), .data_in(data_in), .valid_in(valid_in), .data_out(da), .valid_out(va), .end_pool(ea));
  maxpool_relu #(.dataWidth(16), .M(4), .P(2), .RELU(1)) u_b (.clk(clk), .global_rst(global_rst),
    .ce(ce), .data_in(data_in), .valid_in(valid_in), .data_out(db), .valid_out(vb), .end_pool(eb));
  maxpool_relu #(.dataWidth(16), .M(5), .P(2), .RELU(0)) u_c (.clk(clk), .global_rst(global_rst),
    .ce(ce), .data_in(data_in), .valid_in(valid_in), .data_out(dc), .valid_out(vc), .end_pool(ec));
  maxpool_relu #(.dataWidth(16), .M(7), .P(3), .RELU(1)) u_d (.clk(clk), .global_rst(global_rst),
    .ce(ce), .data_in(data_in), .valid_in(valid_in), .data_out(dd), .valid_out(vd), .end_pool(ed));

  // Anything with valid_out or end_pool high is logged; a stray end_pool shows up as v=0.
  always @(negedge clk) begin
    if (va || ea) got_a.push_back({va, ea, da});
    if (vb || eb) got_b.push_back({vb, eb, db});
    if (vc || ec) got_c.push_back({vc, ec, dc});
    if (vd || ed) got_d.push_back({vd, ed, dd});
  end

  task automatic drive(input logic [15:0] d, input logic v, input logic c);
    data_in = d; valid_in = v; ce = c;
    @(posedge clk); #1;
  endtask

  task automatic clear_q();
    got_a.delete(); got_b.delete(); got_c.delete(); got_d.delete(); exp_q.delete();
  endtask

  task automatic do_reset();
    valid_in = 1'b0; ce = 1'b0; global_rst = 1'b0;
    @(posedge clk); #1;
    global_rst = 1'b1;
    @(posedge clk); #1;
    clear_q();
  endtask

  // Reference: max over each non-overlapping p x p window of the usable region.
  task automatic build_exp(input int m, input int p, input int relu, input int fr[$], input int off);
    int mu, nw, mx, v;
    mu = (m / p) * p; nw = mu / p;
    for (int wr = 0; wr < nw; wr++)
      for (int wc = 0; wc < nw; wc++) begin
        mx = fr[off + wr*p*m + wc*p];
        for (int i = 0; i < p; i++)
          for (int j = 0; j < p; j++) begin
            v = fr[off + (wr*p + i)*m + wc*p + j];
            if (v > mx) mx = v;
          end
        if (relu != 0 && mx < 0) mx = 0;
        exp_q.push_back({1'b1, (wr == nw-1) && (wc == nw-1), 16'(mx)});
      end
  endtask

  task automatic test_reset();
    global_rst = 1'b1; #2;
    global_rst = 1'b0; #1;
    nvec++; if ({va, ea, da} !== 18'd0) begin nerr++; $display("FAIL reset_a got %h want 0", {va, ea, da}); end
    nvec++; if ({vb, eb, db} !== 18'd0) begin nerr++; $display("FAIL reset_b got %h want 0", {vb, eb, db}); end
    nvec++; if ({vc, ec, dc} !== 18'd0) begin nerr++; $display("FAIL reset_c got %h want 0", {vc, ec, dc}); end
    nvec++; if ({vd, ed, dd} !== 18'd0) begin nerr++; $display("FAIL reset_d got %h want 0", {vd, ed, dd}); end
    for (int k = 0; k < 8; k++) drive(16'(k + 5), 1'b1, 1'b1);
    nvec++; if ({va, ea, da} !== 18'd0) begin nerr++; $display("FAIL reset_hold got %h want 0", {va, ea, da}); end
    do_reset();
  endtask

  task automatic test_basic();
    logic ev;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      drive(16'(k), 1'b1, 1'b1);
      ev = (k == 5 || k == 7 || k == 13 || k == 15);
      nvec++; if (va !== ev) begin nerr++; $display("FAIL basic_valid beat %0d got %b want %b", k, va, ev); end
      nvec++; if (ea !== (k == 15)) begin nerr++; $display("FAIL basic_end beat %0d got %b want %b", k, ea, k == 15); end
      if (ev) begin
        nvec++; if (da !== 16'(k)) begin nerr++; $display("FAIL basic_data beat %0d got %0d want %0d", k, da, k); end
      end
    end
    drive(16'd0, 1'b0, 1'b0);
    nvec++; if (va !== 1'b0 || da !== 16'd15) begin nerr++; $display("FAIL basic_hold got v=%b d=%0d want v=0 d=15", va, da); end
  endtask

  task automatic test_relu();
    int fr[$];
    do_reset();
    for (int k = 0; k < 16; k++) begin fr.push_back(-k); drive(16'(-k), 1'b1, 1'b1); end
    drive(16'd0, 1'b0, 1'b0); drive(16'd0, 1'b0, 1'b0);
    build_exp(4, 2, 0, fr, 0);
    nvec++; if (got_a.size() != exp_q.size()) begin nerr++; $display("FAIL relu0_count got %0d want %0d", got_a.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
      nvec++; if (got_a[i] !== exp_q[i]) begin nerr++; $display("FAIL relu0_out %0d got %h want %h", i, got_a[i], exp_q[i]); end
    end
    exp_q.delete();
    build_exp(4, 2, 1, fr, 0);
    nvec++; if (got_b.size() != exp_q.size()) begin nerr++; $display("FAIL relu1_count got %0d want %0d", got_b.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_b.size(); i++) begin
      nvec++; if (got_b[i] !== exp_q[i]) begin nerr++; $display("FAIL relu1_out %0d got %h want %h", i, got_b[i], exp_q[i]); end
    end
  endtask

  task automatic test_unusable();
    int fr[$];
    do_reset();
    for (int k = 0; k < 25; k++) fr.push_back(k);
    for (int k = 0; k < 25; k++) fr.push_back(100 + k);
    foreach (fr[k]) drive(16'(fr[k]), 1'b1, 1'b1);
    drive(16'd0, 1'b0, 1'b0); drive(16'd0, 1'b0, 1'b0);
    build_exp(5, 2, 0, fr, 0);
    build_exp(5, 2, 0, fr, 25);
    nvec++; if (got_c.size() != exp_q.size()) begin nerr++; $display("FAIL m5_count got %0d want %0d", got_c.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_c.size(); i++) begin
      nvec++; if (got_c[i] !== exp_q[i]) begin nerr++; $display("FAIL m5_out %0d got %h want %h", i, got_c[i], exp_q[i]); end
    end
  endtask

  task automatic test_stall();
    int fr[$];
    do_reset();
    for (int k = 0; k < 16; k++) begin
      fr.push_back(k);
      drive(16'(k), 1'b1, 1'b1);
      drive(16'($urandom), 1'b1, 1'b0);
      drive(16'($urandom), 1'b0, 1'b1);
      drive(16'($urandom), 1'b0, 1'b0);
    end
    drive(16'd0, 1'b0, 1'b0);
    build_exp(4, 2, 0, fr, 0);
    nvec++; if (got_a.size() != exp_q.size()) begin nerr++; $display("FAIL stall_count got %0d want %0d", got_a.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
      nvec++; if (got_a[i] !== exp_q[i]) begin nerr++; $display("FAIL stall_out %0d got %h want %h", i, got_a[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int fr[$];
    do_reset();
    for (int k = 0; k < 6; k++) drive(16'(k), 1'b1, 1'b1);
    global_rst = 1'b0; valid_in = 1'b0; #1;
    nvec++; if ({va, ea, da} !== 18'd0) begin nerr++; $display("FAIL midrst_clear got %h want 0", {va, ea, da}); end
    clear_q();
    @(posedge clk); #1;
    global_rst = 1'b1;
    for (int k = 0; k < 16; k++) begin fr.push_back(k); drive(16'(k), 1'b1, 1'b1); end
    drive(16'd0, 1'b0, 1'b0);
    build_exp(4, 2, 0, fr, 0);
    nvec++; if (got_a.size() != exp_q.size()) begin nerr++; $display("FAIL midrst_count got %0d want %0d", got_a.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
      nvec++; if (got_a[i] !== exp_q[i]) begin nerr++; $display("FAIL midrst_out %0d got %h want %h", i, got_a[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int fr[$];
    do_reset();
    for (int k = 0; k < 16; k++) fr.push_back(k);
    for (int k = 0; k < 16; k++) fr.push_back(100 + k);
    foreach (fr[k]) drive(16'(fr[k]), 1'b1, 1'b1);
    drive(16'd0, 1'b0, 1'b0);
    build_exp(4, 2, 0, fr, 0);
    build_exp(4, 2, 0, fr, 16);
    nvec++; if (got_a.size() != exp_q.size()) begin nerr++; $display("FAIL b2b_count got %0d want %0d", got_a.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
      nvec++; if (got_a[i] !== exp_q[i]) begin nerr++; $display("FAIL b2b_out %0d got %h want %h", i, got_a[i], exp_q[i]); end
    end
  endtask

  // Random signed data with random valid/ce gaps; only accepted beats enter the model.
  task automatic test_random_m4();
    int fr[$];
    logic v, c;
    logic [15:0] d;
    do_reset();
    while (fr.size() < 48) begin
      v = ($urandom_range(0, 3) != 0); c = ($urandom_range(0, 4) != 0); d = 16'($urandom);
      if (v && c) fr.push_back(int'($signed(d)));
      drive(d, v, c);
    end
    drive(16'd0, 1'b0, 1'b0);
    for (int f = 0; f < 3; f++) build_exp(4, 2, 0, fr, f*16);
    nvec++; if (got_a.size() != exp_q.size()) begin nerr++; $display("FAIL rnd_a_count got %0d want %0d", got_a.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
      nvec++; if (got_a[i] !== exp_q[i]) begin nerr++; $display("FAIL rnd_a_out %0d got %h want %h", i, got_a[i], exp_q[i]); end
    end
    exp_q.delete();
    for (int f = 0; f < 3; f++) build_exp(4, 2, 1, fr, f*16);
    nvec++; if (got_b.size() != exp_q.size()) begin nerr++; $display("FAIL rnd_b_count got %0d want %0d", got_b.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_b.size(); i++) begin
      nvec++; if (got_b[i] !== exp_q[i]) begin nerr++; $display("FAIL rnd_b_out %0d got %h want %h", i, got_b[i], exp_q[i]); end
    end
  endtask

  task automatic test_random_m7p3();
    int fr[$];
    logic v, c;
    logic [15:0] d;
    do_reset();
    while (fr.size() < 147) begin
      v = ($urandom_range(0, 4) != 0); c = ($urandom_range(0, 5) != 0); d = 16'($urandom);
      if (v && c) fr.push_back(int'($signed(d)));
      drive(d, v, c);
    end
    drive(16'd0, 1'b0, 1'b0);
    for (int f = 0; f < 3; f++) build_exp(7, 3, 1, fr, f*49);
    nvec++; if (got_d.size() != exp_q.size()) begin nerr++; $display("FAIL rnd_d_count got %0d want %0d", got_d.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_d.size(); i++) begin
      nvec++; if (got_d[i] !== exp_q[i]) begin nerr++; $display("FAIL rnd_d_out %0d got %h want %h", i, got_d[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu();
    test_unusable();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_random_m4();
    test_random_m7p3();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
